// File: rtl/line_sequencer.sv
// line_sequencer: buffers line commands, issues them to line_drawer one at a time,
// and runs full-screen clear sweeps that cut in at the next line boundary.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_x0..y1,      line command port (valid/ready)
//   cmd_color
//   clear_req                             request a screen clear (pulse)
//   ld_start, ld_x0..ld_y1, ld_done       line_drawer control/endpoints
//   pixel_write, pixel_color              framebuffer write gate
//   busy, clearing, lines_drawn           status
module line_sequencer #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 11,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_color,
  input  logic               clear_req,
  output logic               ld_start,
  output logic [COORD_W-1:0] ld_x0,
  output logic [COORD_W-1:0] ld_y0,
  output logic [COORD_W-1:0] ld_x1,
  output logic [COORD_W-1:0] ld_y1,
  input  logic               ld_done,
  output logic               pixel_write,
  output logic               pixel_color,
  output logic               busy,
  output logic               clearing,
  output logic [15:0]        lines_drawn
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int EW  = 4 * COORD_W + 1;

  localparam logic [CNW-1:0]     FULL_CNT = CNW'(DEPTH);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(HEIGHT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] DRAW     = 3'd2;
  localparam logic [2:0] CLR_LOAD = 3'd3;
  localparam logic [2:0] CLR_DRAW = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_n;
  logic               clear_pend;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] col_nxt;
  logic [COORD_W-1:0] clr_col;
  logic               last_col;
  logic               color_q;
  logic               first_q;
  logic               done_ok;
  logic               go_load;
  logic               go_clr;

  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CNW-1:0] count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = go_load;
  assign head      = mem[rd_ptr];

  assign clearing    = (state == CLR_LOAD) || (state == CLR_DRAW);
  assign ld_start    = (state == LOAD) || (state == CLR_LOAD);
  assign pixel_write = (state == DRAW) || (state == CLR_DRAW);
  assign pixel_color = (state == DRAW) && color_q;
  assign busy        = (state != IDLE) || !empty;

  // The drawer may still be reporting done from the previous line on the
  // first cycle after its reset, so that cycle never completes a draw.
  assign done_ok  = ld_done && !first_q;
  assign last_col = (col == COL_LAST);
  assign col_nxt  = last_col ? '0 : col + 1'b1;

  assign go_load = (state == IDLE) && !clear_pend && !empty;
  assign go_clr  = ((state == IDLE) && clear_pend) ||
                   ((state == CLR_DRAW) && done_ok && !last_col);
  assign clr_col = (state == CLR_DRAW) ? col_nxt : col;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (clear_pend) state_n = CLR_LOAD;
        else if (!empty) state_n = LOAD;
      end
      LOAD:     state_n = DRAW;
      DRAW:     if (done_ok) state_n = IDLE;
      CLR_LOAD: state_n = CLR_DRAW;
      CLR_DRAW: begin
        if (done_ok) state_n = last_col ? IDLE : CLR_LOAD;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Endpoints are loaded on the edge entering LOAD/CLR_LOAD so they are
  // already valid while the drawer sits in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      clear_pend  <= 1'b0;
      col         <= '0;
      lines_drawn <= '0;
      first_q     <= 1'b0;
      color_q     <= 1'b0;
      ld_x0       <= '0;
      ld_y0       <= '0;
      ld_x1       <= '0;
      ld_y1       <= '0;
    end else begin
      state   <= state_n;
      first_q <= ld_start;
      if ((state == IDLE) && clear_pend)
        clear_pend <= 1'b0;
      else if (clear_req && !clearing)
        clear_pend <= 1'b1;
      if (go_load) begin
        {ld_x0, ld_y0, ld_x1, ld_y1, color_q} <= head;
      end
      if (go_clr) begin
        ld_x0   <= clr_col;
        ld_y0   <= '0;
        ld_x1   <= clr_col;
        ld_y1   <= Y_LAST;
        color_q <= 1'b0;
      end
      if ((state == DRAW) && done_ok)
        lines_drawn <= lines_drawn + 16'd1;
      if ((state == CLR_DRAW) && done_ok)
        col <= col_nxt;
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: scoreboard bench for line_sequencer with a
// behavioural line_drawer (latency, stall and stale-done knobs).
module tb_line_sequencer;

  localparam int CW = 11;

  typedef logic [4*CW+1:0] obs_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x0 = '0;
  logic [CW-1:0] cmd_y0 = '0;
  logic [CW-1:0] cmd_x1 = '0;
  logic [CW-1:0] cmd_y1 = '0;
  logic          cmd_color = 1'b0;
  logic          clear_req = 1'b0;
  logic          ld_start;
  logic [CW-1:0] ld_x0;
  logic [CW-1:0] ld_y0;
  logic [CW-1:0] ld_x1;
  logic [CW-1:0] ld_y1;
  logic          ld_done;
  logic          pixel_write;
  logic          pixel_color;
  logic          busy;
  logic          clearing;
  logic [15:0]   lines_drawn;

  line_sequencer #(
    .WIDTH(4), .HEIGHT(8), .COORD_W(CW), .DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .clear_req(clear_req),
    .ld_start(ld_start),
    .ld_x0(ld_x0), .ld_y0(ld_y0),
    .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_done(ld_done),
    .pixel_write(pixel_write), .pixel_color(pixel_color),
    .busy(busy), .clearing(clearing),
    .lines_drawn(lines_drawn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drawer model: done rises lat edges after leaving reset and stays
  // high until the next ld_start.
  int lat = 3;
  bit hold = 1'b0;
  bit stale = 1'b0;
  int cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_done <= 1'b0;
      cnt     <= 0;
    end else if (ld_start) begin
      ld_done <= stale;
      cnt     <= lat;
    end else if (!hold && cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) ld_done <= 1'b1;
    end
  end

  obs_t expq[$];
  obs_t cap;
  bit   cap_v = 1'b0;
  int   issues = 0;
  int   exp_lines = 0;

  function automatic obs_t mk(input bit clr, input int x0, input int y0,
                              input int x1, input int y1, input bit c);
    return {clr, CW'(x0), CW'(y0), CW'(x1), CW'(y1), c};
  endfunction

  // Endpoints/clearing captured on ld_start, colour on the first DRAW cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cap_v = 1'b0;
    end else begin
      if (cap_v) begin
        obs_t e;
        cap_v = 1'b0;
        check("pw_after_start", 64'(pixel_write), 64'(1));
        check("issue_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("issue", 64'({cap[4*CW+1:1], pixel_color}), 64'(e));
        end
      end
      if (ld_start) begin
        cap = {clearing, ld_x0, ld_y0, ld_x1, ld_y1, 1'b0};
        cap_v = 1'b1;
        issues++;
      end
    end
  end

  task automatic push(input int x0, input int y0, input int x1,
                      input int y1, input bit c, input bit sb);
    int n = 0;
    bit acc = 1'b0;
    cmd_x0 = CW'(x0);
    cmd_y0 = CW'(y0);
    cmd_x1 = CW'(x1);
    cmd_y1 = CW'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
    while (!acc && n < 300) begin
      acc = cmd_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("push_accept", 64'(acc), 64'(1));
    if (acc) begin
      if (sb) expq.push_back(mk(1'b0, x0, y0, x1, y1, c));
      exp_lines++;
    end
  endtask

  task automatic wait_pw(input string tag);
    int n = 0;
    while (!pixel_write && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pw_timeout"}, 64'(n < 200), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || cap_v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(n < 2000), 64'(1));
    check({tag, "_drained"}, 64'(expq.size()), 64'(0));
    check({tag, "_lines"}, 64'(lines_drawn), 64'(exp_lines));
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  initial begin
    int pw_cnt;
    int base;
    int bad;
    int n;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pw", 64'(pixel_write), 64'(0));
    check("rst_start", 64'(ld_start), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_lines", 64'(lines_drawn), 64'(0));
    check("rst_clearing", 64'(clearing), 64'(0));

    // Single line.
    push(10, 20, 30, 20, 1'b1, 1'b1);
    check("single_no_start_yet", 64'(ld_start), 64'(0));
    @(negedge clk);
    check("single_start", 64'(ld_start), 64'(1));
    @(negedge clk);
    check("single_start_1cyc", 64'(ld_start), 64'(0));
    pw_cnt = 0;
    n = 0;
    while (pixel_write && n < 100) begin
      pw_cnt++;
      @(negedge clk);
      n++;
    end
    check("single_pw_cycles", 64'(pw_cnt), 64'(lat + 1));
    check("single_lines", 64'(lines_drawn), 64'(1));
    check("single_busy_fall", 64'(busy), 64'(0));
    wait_idle("single");

    // FIFO full with the drawer stalled.
    hold = 1'b1;
    push(1, 2, 3, 4, 1'b1, 1'b1);
    wait_pw("full");
    push(5, 6, 7, 8, 1'b0, 1'b1);
    push(9, 10, 11, 12, 1'b1, 1'b1);
    push(13, 14, 15, 16, 1'b0, 1'b1);
    push(17, 18, 19, 20, 1'b1, 1'b1);
    check("full_ready_low", 64'(cmd_ready), 64'(0));
    cmd_valid = 1'b1;
    cmd_x0 = CW'(21);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_holdoff", 64'(cmd_ready), 64'(0));
    end
    hold = 1'b0;
    push(21, 22, 23, 24, 1'b1, 1'b1);
    wait_idle("full");

    // Push and pop on the same edge at occupancy 3.
    hold = 1'b1;
    push(100, 1, 101, 1, 1'b1, 1'b1);
    wait_pw("occ");
    push(102, 2, 103, 2, 1'b0, 1'b1);
    push(104, 3, 105, 3, 1'b1, 1'b1);
    push(106, 4, 107, 4, 1'b0, 1'b1);
    hold = 1'b0;
    n = 0;
    while (pixel_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("occ_idle_seen", 64'(ld_start), 64'(0));
    hold = 1'b1;
    push(108, 5, 109, 5, 1'b1, 1'b1);
    check("occ_pop_same_edge", 64'(ld_start), 64'(1));
    check("occ_still_3", 64'(cmd_ready), 64'(1));
    push(110, 6, 111, 6, 1'b0, 1'b1);
    check("occ_now_full", 64'(cmd_ready), 64'(0));
    hold = 1'b0;
    wait_idle("occ");

    // Clear sweep.
    base = issues;
    for (int c = 0; c < 4; c++) expq.push_back(mk(1'b1, c, 0, c, 7, 1'b0));
    pulse_clear();
    n = 0;
    while (!clearing && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_started", 64'(clearing), 64'(1));
    bad = 0;
    n = 0;
    while (busy && n < 500) begin
      if (!clearing) bad++;
      @(negedge clk);
      n++;
    end
    check("clr_continuous", 64'(bad), 64'(0));
    check("clr_starts", 64'(issues - base), 64'(4));
    wait_idle("clr");

    // Clear preempts the queued second command.
    base = issues;
    push(40, 41, 42, 43, 1'b1, 1'b1);
    push(50, 51, 52, 53, 1'b1, 1'b0);
    wait_pw("pre");
    pulse_clear();
    for (int c = 0; c < 4; c++) expq.push_back(mk(1'b1, c, 0, c, 7, 1'b0));
    expq.push_back(mk(1'b0, 50, 51, 52, 53, 1'b1));
    n = 0;
    while (issues < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pre_mid_clear", 64'(clearing), 64'(1));
    pulse_clear();
    wait_idle("pre");
    check("pre_starts", 64'(issues - base), 64'(6));

    // Asynchronous reset mid-draw with commands queued.
    hold = 1'b1;
    push(60, 61, 62, 63, 1'b1, 1'b1);
    wait_pw("rst");
    push(64, 65, 66, 67, 1'b0, 1'b0);
    push(68, 69, 70, 71, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pw", 64'(pixel_write), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_lines", 64'(lines_drawn), 64'(0));
    check("arst_x0", 64'(ld_x0), 64'(0));
    check("arst_color", 64'(pixel_color), 64'(0));
    expq.delete();
    exp_lines = 0;
    hold = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base = issues;
    repeat (12) @(negedge clk);
    check("arst_no_start", 64'(issues - base), 64'(0));
    check("arst_ready", 64'(cmd_ready), 64'(1));
    push(7, 8, 9, 10, 1'b1, 1'b1);
    wait_idle("arst");

    // Stale done held high across LOAD.
    hold = 1'b1;
    stale = 1'b1;
    push(200, 201, 202, 203, 1'b0, 1'b1);
    wait_pw("stale");
    pw_cnt = 0;
    n = 0;
    while (pixel_write && n < 100) begin
      pw_cnt++;
      @(negedge clk);
      n++;
    end
    check("stale_two_cycles", 64'(pw_cnt), 64'(2));
    stale = 1'b0;
    hold = 1'b0;
    wait_idle("stale");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
